frame_readout_seq: RTL and testbench
====================================

Name: frame_readout_seq

Overview:
Parametrised frame serializer and successor to the fixed 53x10 readout counter. On arm it snapshots a frame of NUM_WORDS data words. On each rising edge of the downstream increment strobe it steps word_out through the sequence HEADER, word[0] .. word[NUM_WORDS-1], TRAILER. It then flags completion. It sits between the science word builder and the serial transmitter and adds input synchronisation, frame buffering, abort, underrun detection and a frame counter.

Parameters:
WORD_W, 10, width of each word and of word_out
NUM_WORDS, 53, data words per frame (>=1)
IDX_W, 7, width of word_idx; must satisfy 2**IDX_W > NUM_WORDS
HEADER, 10'h234, word presented before the data words (WORD_W bits)
TRAILER, 10'h0BF, word presented after the last data word (WORD_W bits)
SYNC_STAGES, 2, synchroniser flops on increment (>=2)

Ports:
clk50  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
arm  in  1  pulse: snapshot words_in and start a frame (honoured in IDLE only)
abort  in  1  pulse: terminate the current frame immediately
increment  in  1  step strobe from transmitter, asynchronous to clk50
clr_rdout  in  1  pulse: clear rdout_done and underrun
words_in  in  NUM_WORDS*WORD_W  frame data; word k = bits [k*WORD_W +: WORD_W]
word_out  out  WORD_W  word currently presented to the transmitter
word_idx  out  IDX_W  data words delivered in the current frame (0..NUM_WORDS)
busy  out  1  high in SEND
rdout_done  out  1  sticky: a frame completed
underrun  out  1  sticky: increment edge received while IDLE
frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - word_out=HEADER, word_idx=0, state IDLE, busy=0, rdout_done=0, underrun=0, frame_cnt=0.
  - Synchroniser and edge-detect flops cleared; snapshot buffer cleared to 0.
- Step detect: increment passes through SYNC_STAGES flops, then one edge register.
  - step = sync_out & ~edge_reg.
  - With SYNC_STAGES=2, word_out updates on the 3rd rising clk50 edge that samples increment high.
  - One step per rising edge of increment, regardless of its high time.
- FSM has two states: IDLE and SEND.
- IDLE + arm: snapshot all of words_in into the internal buffer.
  - word_out=HEADER, word_idx=0, busy=1, rdout_done=0, go to SEND.
  - A step in the same cycle is discarded and does not set underrun.
- IDLE + step (no arm): underrun<=1; word_out unchanged.
- SEND + step with word_idx < NUM_WORDS: word_out<=buf[word_idx], word_idx<=word_idx+1.
- SEND + step with word_idx == NUM_WORDS: word_out<=TRAILER, rdout_done<=1, frame_cnt<=frame_cnt+1, word_idx<=0, busy<=0, go to IDLE.
  - TRAILER holds on word_out until the next arm or abort.
- SEND + arm: ignored; the buffer is not reloaded.
- Changes to words_in after arm do not affect the frame in progress.
- abort (any state): word_out<=HEADER, word_idx<=0, busy<=0, go to IDLE.
  - rdout_done and frame_cnt are not changed.
  - abort beats step and arm in the same cycle.
- clr_rdout clears rdout_done and underrun.
  - A set of either flag in the same cycle wins over the clear.
- Full frame length is NUM_WORDS+1 steps after arm: NUM_WORDS data words plus TRAILER.

Test Plan:
- Defaults, words_in word k = k+1, arm, then 54 increment pulses -> word_out = 0x234, 0x001 .. 0x035, then 0x0BF. After the final step: rdout_done=1, frame_cnt=1, busy=0, word_idx=0.
- Latency: single increment rise in SEND -> word_out changes exactly on the 3rd clk50 edge sampling increment high. A 10-cycle-wide pulse gives exactly one step.
- Modify words_in after arm and mid-frame -> delivered words match the arm-time snapshot. A second arm during SEND has no effect.
- Increment pulse in IDLE -> underrun=1 and word_out unchanged. clr_rdout in the same cycle as a further IDLE step -> underrun stays 1. clr_rdout alone -> underrun=0 and rdout_done=0.
- abort after 10 data words -> word_out=0x234, word_idx=0, busy=0, frame_cnt unchanged. A re-arm then delivers a full frame from word[0].
- rst asserted mid-frame at word_idx=20 -> all outputs at reset values immediately, without a clock edge.
- Param sweep WORD_W=16, NUM_WORDS=4, IDX_W=3, HEADER=16'hEB90, TRAILER=16'h146F -> 5 steps give 4 words then 0x146F.
- 256 completed frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/frame_readout_seq_if.sv
// Frame readout bus between the word builder, the sequencer and the transmitter.
// The sequencer is the slave; the surrounding logic drives it as master.
interface frame_readout_seq_if #(
   parameter int WORD_W    = 10,
   parameter int NUM_WORDS = 53,
   parameter int IDX_W     = 7
);
   logic                        arm;
   logic                        abort;
   logic                        increment;
   logic                        clr_rdout;
   logic [NUM_WORDS*WORD_W-1:0] words_in;
   logic [WORD_W-1:0]           word_out;
   logic [IDX_W-1:0]            word_idx;
   logic                        busy;
   logic                        rdout_done;
   logic                        underrun;
   logic [7:0]                  frame_cnt;

   modport master (
      output arm, abort, increment, clr_rdout, words_in,
      input  word_out, word_idx, busy, rdout_done, underrun, frame_cnt
   );

   modport slave (
      input  arm, abort, increment, clr_rdout, words_in,
      output word_out, word_idx, busy, rdout_done, underrun, frame_cnt
   );
endinterface

// File: rtl/frame_readout_seq.sv
// Frame serializer: snapshots a frame on arm and steps HEADER, data words,
// TRAILER out on each rising edge of the asynchronous increment strobe.
module frame_readout_seq #(
   parameter int              WORD_W      = 10,
   parameter int              NUM_WORDS   = 53,
   parameter int              IDX_W       = 7,
   parameter logic [WORD_W-1:0] HEADER    = 'h234,
   parameter logic [WORD_W-1:0] TRAILER   = 'h0BF,
   parameter int              SYNC_STAGES = 2
) (
   input logic                 clk50,
   input logic                 rst,
   frame_readout_seq_if.slave  bus
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                  state_q;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    edge_q;
   logic                    sync_out;
   logic                    step;
   logic [WORD_W-1:0]       buf_q [NUM_WORDS];
   logic [WORD_W-1:0]       rd_word;
   logic [WORD_W-1:0]       word_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    under_q;
   logic [7:0]              cnt_q;
   logic                    load;
   logic                    last;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign step     = sync_out & ~edge_q;
   assign load     = (state_q == IDLE) & bus.arm & ~bus.abort;
   assign last     = (idx_q == IDX_W'(NUM_WORDS));

   // Synchronise increment and keep the last synced level for edge detect.
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.increment};
         edge_q <= sync_out;
      end
   end

   // Frame buffer: captured once per frame so later words_in changes are ignored.
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            buf_q[k] <= '0;
         end
      end else if (load) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            buf_q[k] <= bus.words_in[k*WORD_W +: WORD_W];
         end
      end
   end

   // Select the buffered word addressed by the delivered-word count.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            rd_word = buf_q[k];
         end
      end
   end

   // Sequencer: abort has priority, then arm/step handling per state.
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= HEADER;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         under_q <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         // Clear first so a same-cycle set below overrides it.
         if (bus.clr_rdout) begin
            done_q  <= 1'b0;
            under_q <= 1'b0;
         end
         if (bus.abort) begin
            state_q <= IDLE;
            word_q  <= HEADER;
            idx_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (bus.arm) begin
                     state_q <= SEND;
                     word_q  <= HEADER;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end else if (step) begin
                     under_q <= 1'b1;
                  end
               end
               SEND: begin
                  if (step) begin
                     if (last) begin
                        state_q <= IDLE;
                        word_q  <= TRAILER;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= cnt_q + 8'd1;
                     end else begin
                        word_q  <= rd_word;
                        idx_q   <= idx_q + IDX_W'(1);
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.word_out   = word_q;
   assign bus.word_idx   = idx_q;
   assign bus.busy       = busy_q;
   assign bus.rdout_done = done_q;
   assign bus.underrun   = under_q;
   assign bus.frame_cnt  = cnt_q;

endmodule

// File: tb/tb_frame_readout_seq.sv
// Directed bench for frame_readout_seq: default 53x10 instance plus a
// 4x16 instance for the parameter sweep and frame counter wrap.
module tb_frame_readout_seq;

   logic         clk50 = 1'b0;
   logic         rst = 1'b1;
   logic         arm = 1'b0;
   logic         abort = 1'b0;
   logic         inc = 1'b0;
   logic         clr = 1'b0;
   logic [529:0] words_a = '0;
   logic [63:0]  words_b = '0;

   int total = 0;
   int bad = 0;

   always #10 clk50 = ~clk50;

   frame_readout_seq_if ifa ();
   frame_readout_seq_if #(.WORD_W(16), .NUM_WORDS(4), .IDX_W(3)) ifb ();

   assign ifa.arm = arm;
   assign ifa.abort = abort;
   assign ifa.increment = inc;
   assign ifa.clr_rdout = clr;
   assign ifa.words_in = words_a;
   assign ifb.arm = arm;
   assign ifb.abort = abort;
   assign ifb.increment = inc;
   assign ifb.clr_rdout = clr;
   assign ifb.words_in = words_b;

   frame_readout_seq dut_a (
      .clk50 (clk50),
      .rst   (rst),
      .bus   (ifa)
   );

   frame_readout_seq #(
      .WORD_W    (16),
      .NUM_WORDS (4),
      .IDX_W     (3),
      .HEADER    (16'hEB90),
      .TRAILER   (16'h146F)
   ) dut_b (
      .clk50 (clk50),
      .rst   (rst),
      .bus   (ifb)
   );

   task automatic do_step();
      @(negedge clk50);
      inc = 1'b1;
      repeat (2) @(negedge clk50);
      inc = 1'b0;
      repeat (3) @(negedge clk50);
   endtask

   task automatic do_arm();
      @(negedge clk50);
      arm = 1'b1;
      @(negedge clk50);
      arm = 1'b0;
   endtask

   task automatic do_abort();
      @(negedge clk50);
      abort = 1'b1;
      @(negedge clk50);
      abort = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk50);
      total++; if (ifa.word_out !== 10'h234) begin bad++; $display("FAIL rst_word got=%h exp=234", ifa.word_out); end
      total++; if (ifa.word_idx !== 7'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", ifa.word_idx); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", ifa.busy); end
      total++; if (ifa.rdout_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", ifa.rdout_done); end
      total++; if (ifa.underrun !== 1'b0) begin bad++; $display("FAIL rst_under got=%b exp=0", ifa.underrun); end
      total++; if (ifa.frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", ifa.frame_cnt); end
      rst = 1'b0;
      repeat (2) @(negedge clk50);
   endtask

   task automatic test_full_frame();
      for (int k = 0; k < 53; k++) words_a[k*10 +: 10] = 10'(k + 1);
      do_arm();
      total++; if (ifa.word_out !== 10'h234) begin bad++; $display("FAIL ff_hdr got=%h exp=234", ifa.word_out); end
      total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL ff_busy got=%b exp=1", ifa.busy); end
      for (int k = 0; k < 53; k++) begin
         do_step();
         total++; if (ifa.word_out !== 10'(k + 1)) begin bad++; $display("FAIL ff_word%0d got=%h exp=%h", k, ifa.word_out, 10'(k + 1)); end
         total++; if (ifa.word_idx !== 7'(k + 1)) begin bad++; $display("FAIL ff_idx%0d got=%0d exp=%0d", k, ifa.word_idx, k + 1); end
      end
      do_step();
      total++; if (ifa.word_out !== 10'h0BF) begin bad++; $display("FAIL ff_trl got=%h exp=0bf", ifa.word_out); end
      total++; if (ifa.rdout_done !== 1'b1) begin bad++; $display("FAIL ff_done got=%b exp=1", ifa.rdout_done); end
      total++; if (ifa.frame_cnt !== 8'd1) begin bad++; $display("FAIL ff_cnt got=%0d exp=1", ifa.frame_cnt); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL ff_busy_end got=%b exp=0", ifa.busy); end
      total++; if (ifa.word_idx !== 7'd0) begin bad++; $display("FAIL ff_idx_end got=%0d exp=0", ifa.word_idx); end
      repeat (3) @(negedge clk50);
      total++; if (ifa.word_out !== 10'h0BF) begin bad++; $display("FAIL ff_trl_hold got=%h exp=0bf", ifa.word_out); end
   endtask

   task automatic test_latency();
      do_arm();
      total++; if (ifa.rdout_done !== 1'b0) begin bad++; $display("FAIL lat_done_clr got=%b exp=0", ifa.rdout_done); end
      @(negedge clk50);
      inc = 1'b1;
      repeat (2) @(posedge clk50);
      #1;
      total++; if (ifa.word_out !== 10'h234) begin bad++; $display("FAIL lat_edge2 got=%h exp=234", ifa.word_out); end
      @(posedge clk50);
      #1;
      total++; if (ifa.word_out !== 10'h001) begin bad++; $display("FAIL lat_edge3 got=%h exp=001", ifa.word_out); end
      repeat (8) @(negedge clk50);
      inc = 1'b0;
      repeat (4) @(negedge clk50);
      total++; if (ifa.word_idx !== 7'd1) begin bad++; $display("FAIL lat_wide got=%0d exp=1", ifa.word_idx); end
   endtask

   task automatic test_snapshot();
      for (int k = 0; k < 53; k++) words_a[k*10 +: 10] = 10'(k + 100);
      do_arm();
      total++; if (ifa.word_idx !== 7'd1) begin bad++; $display("FAIL snap_rearm_idx got=%0d exp=1", ifa.word_idx); end
      total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL snap_rearm_busy got=%b exp=1", ifa.busy); end
      for (int i = 1; i < 10; i++) begin
         do_step();
         total++; if (ifa.word_out !== 10'(i + 1)) begin bad++; $display("FAIL snap_word%0d got=%h exp=%h", i, ifa.word_out, 10'(i + 1)); end
      end
      total++; if (ifa.word_idx !== 7'd10) begin bad++; $display("FAIL snap_idx got=%0d exp=10", ifa.word_idx); end
   endtask

   task automatic test_abort();
      do_abort();
      total++; if (ifa.word_out !== 10'h234) begin bad++; $display("FAIL ab_word got=%h exp=234", ifa.word_out); end
      total++; if (ifa.word_idx !== 7'd0) begin bad++; $display("FAIL ab_idx got=%0d exp=0", ifa.word_idx); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%b exp=0", ifa.busy); end
      total++; if (ifa.frame_cnt !== 8'd1) begin bad++; $display("FAIL ab_cnt got=%0d exp=1", ifa.frame_cnt); end
      total++; if (ifa.rdout_done !== 1'b0) begin bad++; $display("FAIL ab_done got=%b exp=0", ifa.rdout_done); end
      do_arm();
      for (int k = 0; k < 53; k++) begin
         do_step();
         total++; if (ifa.word_out !== 10'(k + 100)) begin bad++; $display("FAIL rearm_word%0d got=%h exp=%h", k, ifa.word_out, 10'(k + 100)); end
      end
      do_step();
      total++; if (ifa.word_out !== 10'h0BF) begin bad++; $display("FAIL rearm_trl got=%h exp=0bf", ifa.word_out); end
      total++; if (ifa.frame_cnt !== 8'd2) begin bad++; $display("FAIL rearm_cnt got=%0d exp=2", ifa.frame_cnt); end
      total++; if (ifa.rdout_done !== 1'b1) begin bad++; $display("FAIL rearm_done got=%b exp=1", ifa.rdout_done); end
   endtask

   task automatic test_underrun();
      do_step();
      total++; if (ifa.underrun !== 1'b1) begin bad++; $display("FAIL ur_set got=%b exp=1", ifa.underrun); end
      total++; if (ifa.word_out !== 10'h0BF) begin bad++; $display("FAIL ur_word got=%h exp=0bf", ifa.word_out); end
      @(negedge clk50);
      inc = 1'b1;
      repeat (2) @(negedge clk50);
      inc = 1'b0;
      clr = 1'b1;
      @(negedge clk50);
      clr = 1'b0;
      repeat (3) @(negedge clk50);
      total++; if (ifa.underrun !== 1'b1) begin bad++; $display("FAIL ur_set_wins got=%b exp=1", ifa.underrun); end
      total++; if (ifa.rdout_done !== 1'b0) begin bad++; $display("FAIL ur_done_clr got=%b exp=0", ifa.rdout_done); end
      @(negedge clk50);
      clr = 1'b1;
      @(negedge clk50);
      clr = 1'b0;
      total++; if (ifa.underrun !== 1'b0) begin bad++; $display("FAIL ur_clr got=%b exp=0", ifa.underrun); end
      total++; if (ifa.rdout_done !== 1'b0) begin bad++; $display("FAIL ur_clr_done got=%b exp=0", ifa.rdout_done); end
   endtask

   task automatic test_arm_with_step();
      @(negedge clk50);
      inc = 1'b1;
      repeat (2) @(negedge clk50);
      inc = 1'b0;
      arm = 1'b1;
      @(negedge clk50);
      arm = 1'b0;
      repeat (3) @(negedge clk50);
      total++; if (ifa.underrun !== 1'b0) begin bad++; $display("FAIL as_under got=%b exp=0", ifa.underrun); end
      total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL as_busy got=%b exp=1", ifa.busy); end
      total++; if (ifa.word_idx !== 7'd0) begin bad++; $display("FAIL as_idx got=%0d exp=0", ifa.word_idx); end
      total++; if (ifa.word_out !== 10'h234) begin bad++; $display("FAIL as_word got=%h exp=234", ifa.word_out); end
      do_abort();
   endtask

   task automatic test_reset_mid();
      do_arm();
      for (int k = 0; k < 20; k++) do_step();
      total++; if (ifa.word_idx !== 7'd20) begin bad++; $display("FAIL rm_pre_idx got=%0d exp=20", ifa.word_idx); end
      total++; if (ifa.word_out !== 10'd119) begin bad++; $display("FAIL rm_pre_word got=%h exp=077", ifa.word_out); end
      @(negedge clk50);
      #2;
      rst = 1'b1;
      #1;
      total++; if (ifa.word_out !== 10'h234) begin bad++; $display("FAIL rm_word got=%h exp=234", ifa.word_out); end
      total++; if (ifa.word_idx !== 7'd0) begin bad++; $display("FAIL rm_idx got=%0d exp=0", ifa.word_idx); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", ifa.busy); end
      total++; if (ifa.frame_cnt !== 8'd0) begin bad++; $display("FAIL rm_cnt got=%0d exp=0", ifa.frame_cnt); end
      total++; if (ifa.rdout_done !== 1'b0) begin bad++; $display("FAIL rm_done got=%b exp=0", ifa.rdout_done); end
      @(negedge clk50);
      rst = 1'b0;
      repeat (2) @(negedge clk50);
   endtask

   task automatic test_param_sweep();
      words_b = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      do_arm();
      total++; if (ifb.word_out !== 16'hEB90) begin bad++; $display("FAIL ps_hdr got=%h exp=eb90", ifb.word_out); end
      for (int k = 0; k < 4; k++) begin
         do_step();
         total++; if (ifb.word_out !== 16'(16'h1111 * (k + 1))) begin bad++; $display("FAIL ps_word%0d got=%h exp=%h", k, ifb.word_out, 16'(16'h1111 * (k + 1))); end
      end
      do_step();
      total++; if (ifb.word_out !== 16'h146F) begin bad++; $display("FAIL ps_trl got=%h exp=146f", ifb.word_out); end
      total++; if (ifb.frame_cnt !== 8'd1) begin bad++; $display("FAIL ps_cnt got=%0d exp=1", ifb.frame_cnt); end
      total++; if (ifb.word_idx !== 3'd0) begin bad++; $display("FAIL ps_idx got=%0d exp=0", ifb.word_idx); end
   endtask

   task automatic test_wrap();
      for (int f = 1; f < 255; f++) begin
         do_arm();
         repeat (5) do_step();
      end
      total++; if (ifb.frame_cnt !== 8'd255) begin bad++; $display("FAIL wr_255 got=%0d exp=255", ifb.frame_cnt); end
      do_arm();
      repeat (5) do_step();
      total++; if (ifb.frame_cnt !== 8'd0) begin bad++; $display("FAIL wr_0 got=%0d exp=0", ifb.frame_cnt); end
      total++; if (ifb.rdout_done !== 1'b1) begin bad++; $display("FAIL wr_done got=%b exp=1", ifb.rdout_done); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_latency();
      test_snapshot();
      test_abort();
      test_underrun();
      test_arm_with_step();
      test_reset_mid();
      test_param_sweep();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
